// File: rtl/adc_x2_sample_scheduler.sv
// rtl/adc_x2_sample_scheduler.sv - paced single-conversion sequencer for the dual ADC7476A core
//
// Purpose: runs a sample-rate timer and, on each tick, drives one conversion of the
// dual-ADC core through its start/enable/IRQ-clear controls. Captures channels A/B when
// the core reports ready and acknowledges it, then streams {Seq, B, A} to a DMA/packer
// through a 2-entry first-word fall-through FIFO.
//
// Ports:
//   SysClk, RST_n              clock, asynchronous active-low reset
//   Enable                     run request; a rising edge from idle starts a new run
//   SamplePeriod[23:0]         SysClk cycles per trigger, clamped to >= MIN_PERIOD
//   NumSamples[15:0]           samples per run, 0 = free-run until Enable drops
//   ClkDiv_In / Adc_ClkDiv     ADC SCLK divider, passed straight through
//   Adc_ChipEnable             core enable (= Enable)
//   Adc_Start                  core single-conversion start, high through LAUNCH/CONVERT
//   Adc_IrqClear               one-cycle acknowledge of the core ready flag
//   Adc_Busy, Adc_Ready        core status
//   Adc_Data_A/B[11:0]         core conversion results
//   M_Valid/M_Ready/M_Data     sample stream, M_Data = {Seq[7:0], B[11:0], A[11:0]}
//   Busy                       sequencer not idle
//   Done, Error                sticky: run complete / core timeout
//   SampleCnt[15:0]            samples captured since start (wraps)
//   OverrunCnt[7:0]            triggers missed while not waiting (saturating)
//   DropCnt[7:0]               samples lost on a full FIFO (saturating)
module adc_x2_sample_scheduler #(
    parameter int CLKDIV_W     = 4,
    parameter int MIN_PERIOD   = 64,
    parameter int TIMEOUT_CLKS = 4096
) (
    input  logic                SysClk,
    input  logic                RST_n,
    input  logic                Enable,
    input  logic [23:0]         SamplePeriod,
    input  logic [15:0]         NumSamples,
    input  logic [CLKDIV_W-1:0] ClkDiv_In,
    output logic                Adc_ChipEnable,
    output logic                Adc_Start,
    output logic [CLKDIV_W-1:0] Adc_ClkDiv,
    output logic                Adc_IrqClear,
    input  logic                Adc_Busy,
    input  logic                Adc_Ready,
    input  logic [11:0]         Adc_Data_A,
    input  logic [11:0]         Adc_Data_B,
    output logic                M_Valid,
    input  logic                M_Ready,
    output logic [31:0]         M_Data,
    output logic                Busy,
    output logic                Done,
    output logic                Error,
    output logic [15:0]         SampleCnt,
    output logic [7:0]          OverrunCnt,
    output logic [7:0]          DropCnt
);
    localparam int              TO_W    = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [23:0]     MIN_P   = 24'(MIN_PERIOD);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CLKS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_LAUNCH,
        S_CONVERT,
        S_CAPTURE,
        S_CLEAR
    } state_t;

    state_t          state_q, state_d;
    logic            enable_q;
    logic [23:0]     timer_q, timer_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            done_q, done_d;
    logic            error_q, error_d;
    logic [7:0]      seq_q, seq_d;
    logic [15:0]     sample_cnt_q, sample_cnt_d;
    logic [7:0]      overrun_q, overrun_d;
    logic [7:0]      drop_q, drop_d;

    logic [31:0]     fifo_mem_q [2];
    logic            fifo_wr_ptr_q;
    logic            fifo_rd_ptr_q;
    logic [1:0]      fifo_cnt_q;

    logic            start_run;
    logic            tick;
    logic            timed_out;
    logic            push_req;
    logic            fifo_pop;
    logic            fifo_accept;
    logic            fifo_push;
    logic [23:0]     period_m1;

    // A rising Enable only starts a run from idle; mid-frame edges are ignored.
    assign start_run   = Enable & ~enable_q & (state_q == S_IDLE);
    assign period_m1   = ((SamplePeriod < MIN_P) ? MIN_P : SamplePeriod) - 24'd1;
    assign tick        = Enable & (state_q != S_IDLE) & (timer_q == 24'd0);
    assign timed_out   = (to_cnt_q == TO_LAST);

    assign fifo_pop    = M_Valid & M_Ready;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign fifo_accept = (fifo_cnt_q != 2'd2) | fifo_pop;
    assign fifo_push   = push_req & fifo_accept;

    assign Adc_ChipEnable = Enable;
    assign Adc_ClkDiv     = ClkDiv_In;
    assign M_Valid        = (fifo_cnt_q != 2'd0);
    assign M_Data         = fifo_mem_q[fifo_rd_ptr_q];
    assign Busy           = (state_q != S_IDLE);
    assign Done           = done_q;
    assign Error          = error_q;
    assign SampleCnt      = sample_cnt_q;
    assign OverrunCnt     = overrun_q;
    assign DropCnt        = drop_q;

    // Sample-rate timer: loaded on run start so the first tick lands one period later.
    always_comb begin
        timer_d = timer_q;
        if (start_run) begin
            timer_d = period_m1;
        end else if (!Enable || (state_q == S_IDLE)) begin
            timer_d = 24'd0;
        end else if (timer_q == 24'd0) begin
            timer_d = period_m1;
        end else begin
            timer_d = timer_q - 24'd1;
        end
    end

    always_comb begin
        state_d      = state_q;
        Adc_Start    = 1'b0;
        Adc_IrqClear = 1'b0;
        push_req     = 1'b0;
        done_d       = done_q;
        error_d      = error_q;
        seq_d        = seq_q;
        sample_cnt_d = sample_cnt_q;
        overrun_d    = overrun_q;
        drop_d       = drop_q;

        unique case (state_q)
            S_IDLE: begin
                if (start_run) begin
                    state_d      = S_WAIT;
                    done_d       = 1'b0;
                    error_d      = 1'b0;
                    seq_d        = 8'd0;
                    sample_cnt_d = 16'd0;
                    overrun_d    = 8'd0;
                    drop_d       = 8'd0;
                end
            end
            S_WAIT: begin
                if (!Enable) begin
                    state_d = S_IDLE;
                end else if (tick) begin
                    state_d = S_LAUNCH;
                end
            end
            S_LAUNCH, S_CONVERT: begin
                if (timed_out) begin
                    // Abort: drop start and clear whatever the core may have flagged.
                    error_d      = 1'b1;
                    Adc_IrqClear = 1'b1;
                    state_d      = S_IDLE;
                end else begin
                    Adc_Start = 1'b1;
                    if ((state_q == S_LAUNCH) && Adc_Busy) begin
                        state_d = S_CONVERT;
                    end else if ((state_q == S_CONVERT) && Adc_Ready && !Adc_Busy) begin
                        state_d = S_CAPTURE;
                    end
                end
            end
            S_CAPTURE: begin
                push_req     = 1'b1;
                Adc_IrqClear = 1'b1;
                seq_d        = seq_q + 8'd1;
                sample_cnt_d = sample_cnt_q + 16'd1;
                if (!fifo_accept && (drop_q != 8'hFF)) begin
                    drop_d = drop_q + 8'd1;
                end
                state_d = S_CLEAR;
            end
            S_CLEAR: begin
                if (!Adc_Ready) begin
                    if ((NumSamples != 16'd0) && (sample_cnt_q == NumSamples)) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else if (!Enable) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Triggers arriving while a frame is still in flight are counted, not queued.
        if (tick && (state_q != S_WAIT) && (overrun_d != 8'hFF)) begin
            overrun_d = overrun_d + 8'd1;
        end
    end

    // Cycles spent in the current state; restarts on every transition.
    always_comb begin
        if (state_d != state_q) begin
            to_cnt_d = '0;
        end else if (to_cnt_q != TO_LAST) begin
            to_cnt_d = to_cnt_q + TO_W'(1);
        end else begin
            to_cnt_d = to_cnt_q;
        end
    end

    always_ff @(posedge SysClk or negedge RST_n) begin
        if (!RST_n) begin
            state_q      <= S_IDLE;
            enable_q     <= 1'b0;
            timer_q      <= 24'd0;
            to_cnt_q     <= '0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            seq_q        <= 8'd0;
            sample_cnt_q <= 16'd0;
            overrun_q    <= 8'd0;
            drop_q       <= 8'd0;
        end else begin
            state_q      <= state_d;
            enable_q     <= Enable;
            timer_q      <= timer_d;
            to_cnt_q     <= to_cnt_d;
            done_q       <= done_d;
            error_q      <= error_d;
            seq_q        <= seq_d;
            sample_cnt_q <= sample_cnt_d;
            overrun_q    <= overrun_d;
            drop_q       <= drop_d;
        end
    end

    always_ff @(posedge SysClk or negedge RST_n) begin
        if (!RST_n) begin
            fifo_mem_q[0] <= 32'd0;
            fifo_mem_q[1] <= 32'd0;
            fifo_wr_ptr_q <= 1'b0;
            fifo_rd_ptr_q <= 1'b0;
            fifo_cnt_q    <= 2'd0;
        end else begin
            if (fifo_push) begin
                fifo_mem_q[fifo_wr_ptr_q] <= {seq_q, Adc_Data_B, Adc_Data_A};
                fifo_wr_ptr_q             <= ~fifo_wr_ptr_q;
            end
            if (fifo_pop) begin
                fifo_rd_ptr_q <= ~fifo_rd_ptr_q;
            end
            case ({fifo_push, fifo_pop})
                2'b10:   fifo_cnt_q <= fifo_cnt_q + 2'd1;
                2'b01:   fifo_cnt_q <= fifo_cnt_q - 2'd1;
                default: fifo_cnt_q <= fifo_cnt_q;
            endcase
        end
    end

endmodule
